prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, program buffer entries; power of two, 2..16.
REQ-002 Parameter HALT_WORD, default 8'hFF, instruction value that ends the program without being issued.
REQ-003 clock  input  1  system clock, rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 load_en  input  1  write load_data into buffer at write pointer (accepted in IDLE only).
REQ-006 load_data  input  8  instruction word {mode, opcode[2:0], RegA[1:0], RegB[1:0]}.
REQ-007 clear  input  1  synchronous pulse: empty buffer, pc to 0, return to IDLE.
REQ-008 run  input  1  level: free-run the stored program.
REQ-009 step  input  1  one-cycle pulse: issue exactly one instruction.
REQ-010 loop_en  input  1  restart at pc 0 after the last entry instead of halting.
REQ-011 instr_out  output  8  instruction presented to the CPU core.
REQ-012 instr_valid  output  1  instr_out is valid for the core.
REQ-013 instr_ready  input  1  core accepts instr_out (its Fetch state).
REQ-014 core_done  input  1  one-cycle pulse, core finished Write-back.
REQ-015 pc  output  clog2(DEPTH)  index of the current/next instruction.
REQ-016 prog_len  output  clog2(DEPTH)+1  number of stored instructions.
REQ-017 busy  output  1  state is ISSUE or WAIT.
REQ-018 halted  output  1  state is HALT.
REQ-019 load_ovf  output  1  sticky: load_en seen while buffer full.

Function
REQ-020 States SHALL be IDLE, ISSUE, WAIT, HALT; encoding 2 bits, IDLE=0, ISSUE=1, WAIT=2, HALT=3.
REQ-021 IDLE: load_en with prog_len<DEPTH SHALL write mem[prog_len] and increment prog_len next cycle.
REQ-022 IDLE: load_en with prog_len==DEPTH SHALL drop the write and set load_ovf.
REQ-023 IDLE: run=1 and prog_len>0 SHALL go to ISSUE (free-run mode); step=1 and prog_len>0 SHALL go to ISSUE (single mode); run takes priority over step; prog_len==0 SHALL stay IDLE.
REQ-024 ISSUE: if mem[pc]==HALT_WORD SHALL go to HALT with instr_valid=0 for that cycle.
REQ-025 ISSUE: instr_valid=1, instr_out=mem[pc]; instr_out SHALL be held stable until instr_ready=1, then go to WAIT.
REQ-026 WAIT: instr_valid=0; core_done SHALL advance pc and select next state as below.
REQ-027 Next after core_done: if pc was prog_len-1 -> pc=0 and (loop_en ? ISSUE : HALT); else single mode -> IDLE; else ISSUE.
REQ-028 Single mode with loop_en and last entry SHALL go to IDLE with pc=0.
REQ-029 Deasserting run during ISSUE/WAIT SHALL complete the in-flight instruction, then go to IDLE; pc retained so run resumes.
REQ-030 core_done outside WAIT SHALL be ignored.
REQ-031 load_en outside IDLE SHALL be ignored and SHALL NOT set load_ovf.
REQ-032 clear SHALL take priority over all other inputs in every state; prog_len, pc, load_ovf to 0, state IDLE next cycle.
REQ-033 HALT: exits only on clear or reset; run/step ignored.
REQ-034 Latency: run asserted in IDLE -> instr_valid high on the next cycle.

Reset
REQ-035 resetn low SHALL immediately force state IDLE, pc=0, prog_len=0, load_ovf=0, instr_valid=0, instr_out=8'h00, busy=0, halted=0.
REQ-036 Reset mid-ISSUE/WAIT SHALL abandon the instruction; buffer contents need not be cleared (prog_len=0 makes them invisible).

Structure
REQ-037 State encoding, instruction field positions and HALT_WORD default SHALL live in shared package cpu_pkg, reused by control_unit.
REQ-038 Buffer SHALL be one sub-module prog_buffer (synchronous write, combinational read, no reset on storage).

Verification
REQ-039 Load 8'h30, 8'h30, 8'h10, run=1, core model done 3 cycles after ready -> three issues in order, halted=1, pc=0, prog_len=3.
REQ-040 Load 8 words, 9th load_en -> prog_len=8, load_ovf=1, mem[7] unchanged.
REQ-041 Load 8'h30, 8'hFF, 8'h10, run -> only 8'h30 issued, halted=1, 8'h10 never valid.
REQ-042 Load 2 words, step twice -> one issue per step, IDLE between, pc 0->1->0.
REQ-043 Load 2 words, loop_en=1, run for 5 core_done -> issue sequence w0,w1,w0,w1,w0, never HALT.
REQ-044 resetn low during WAIT -> instr_valid=0, state IDLE, prog_len=0 asynchronously; clear in HALT -> IDLE next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, instruction field layout, halt word.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Instruction word layout: {mode, opcode[2:0], reg_a[1:0], reg_b[1:0]}.
// The control unit decodes the same fields, so both sides take the bit
// positions from here rather than hard-coding them.
package cpu_pkg;

    // Sequencer state encoding. Kept as plain 2-bit constants so the values
    // stay fixed for code that compares raw state bits.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Instruction word width and field positions.
    localparam int INSTR_W  = 8;
    localparam int MODE_BIT = 7;
    localparam int OPC_MSB  = 6;
    localparam int OPC_LSB  = 4;
    localparam int REGA_MSB = 3;
    localparam int REGA_LSB = 2;
    localparam int REGB_MSB = 1;
    localparam int REGB_LSB = 0;

    // Word that terminates a stored program; it is never handed to the core.
    localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 8'hFF;

    function automatic logic instr_mode(input logic [INSTR_W-1:0] w);
        return w[MODE_BIT];
    endfunction

    function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [1:0] instr_rega(input logic [INSTR_W-1:0] w);
        return w[REGA_MSB:REGA_LSB];
    endfunction

    function automatic logic [1:0] instr_regb(input logic [INSTR_W-1:0] w);
        return w[REGB_MSB:REGB_LSB];
    endfunction

endpackage

// File: rtl/prog_buffer.sv
// Program storage for the sequencer: DEPTH x 8-bit words.
// Latency: write lands on the next rising edge; read is combinational from raddr.
// Backpressure: none; the owner decides when writing is allowed.
//
// Ports:
//   clock        write clock
//   wr_en/waddr/wdata  synchronous write port
//   raddr/rdata  asynchronous read port
// Storage has no reset: the owner tracks how many entries are meaningful.
module prog_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: stores a short instruction program and feeds it to the CPU core one word at a time.
// Latency: run/step in IDLE -> instr_valid on the next cycle; next word one cycle after core_done.
// Backpressure: instr_out held stable while instr_valid && !instr_ready; next word only after core_done.
//
// Ports:
//   clock, resetn             rising-edge clock, asynchronous active-low reset
//   load_en, load_data        append a word to the program (IDLE only)
//   clear                     synchronous wipe: empty program, pc 0, IDLE
//   run, step, loop_en        free-run level / single-issue pulse / wrap at end of program
//   instr_out, instr_valid,   instruction handshake towards the core
//   instr_ready, core_done    core accepted the word / core finished write-back
//   pc, prog_len              current index, number of stored words
//   busy, halted, load_ovf    ISSUE|WAIT, HALT, sticky overflow on load into a full buffer
module prog_sequencer
    import cpu_pkg::*;
#(
    parameter int                 DEPTH     = 8,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       load_en,
    input  logic [INSTR_W-1:0]         load_data,
    input  logic                       clear,
    input  logic                       run,
    input  logic                       step,
    input  logic                       loop_en,
    output logic [INSTR_W-1:0]         instr_out,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    input  logic                       core_done,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic [$clog2(DEPTH):0]     prog_len,
    output logic                       busy,
    output logic                       halted,
    output logic                       load_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

    logic [1:0]         state_q,  state_d;
    logic [AW-1:0]      pc_q,     pc_d;
    logic [AW:0]        len_q,    len_d;
    logic               ovf_q,    ovf_d;
    // Set when the current pass was started by step; the pass then ends in
    // IDLE after one instruction instead of continuing.
    logic               single_q, single_d;

    logic               wr_en;
    logic [INSTR_W-1:0] rdata;
    logic               cur_is_halt;
    logic               pc_is_last;
    logic               has_prog;

    prog_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock (clock),
        .wr_en (wr_en),
        .waddr (len_q[AW-1:0]),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (rdata)
    );

    assign cur_is_halt = (rdata == HALT_WORD);
    // pc only ever indexes stored words, so pc < len_q whenever len_q > 0.
    assign pc_is_last  = ({1'b0, pc_q} == (len_q - LEN_ONE));
    assign has_prog    = (len_q != '0);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        single_d = single_q;
        wr_en    = 1'b0;

        if (clear) begin
            state_d  = ST_IDLE;
            pc_d     = '0;
            len_d    = '0;
            ovf_d    = 1'b0;
            single_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The write address is len_q, so a full buffer would wrap
                    // onto entry 0; block the write and flag it instead.
                    if (load_en) begin
                        if (len_q != LEN_FULL) begin
                            wr_en = 1'b1;
                            len_d = len_q + LEN_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (has_prog) begin
                        if (run) begin
                            state_d  = ST_ISSUE;
                            single_d = 1'b0;
                        end else if (step) begin
                            state_d  = ST_ISSUE;
                            single_d = 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    // A halt word ends the program without being presented.
                    if (cur_is_halt) begin
                        state_d = ST_HALT;
                    end else if (instr_ready) begin
                        state_d = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (core_done) begin
                        if (pc_is_last) begin
                            pc_d = '0;
                            if (!loop_en) begin
                                state_d = ST_HALT;
                            end else if (single_q || !run) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_ISSUE;
                            end
                        end else begin
                            pc_d = pc_q + 1'b1;
                            // Dropping run mid-instruction parks in IDLE with
                            // pc already advanced, so raising run resumes.
                            if (single_q || !run) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_ISSUE;
                            end
                        end
                    end
                end

                ST_HALT: begin
                    // Only clear or reset leave HALT.
                    state_d = ST_HALT;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            single_q <= single_d;
        end
    end

    // Outputs decode straight from state so reset takes effect immediately.
    // instr_out is zeroed whenever it is not valid.
    assign instr_valid = (state_q == ST_ISSUE) && !cur_is_halt;
    assign instr_out   = instr_valid ? rdata : '0;
    assign pc          = pc_q;
    assign prog_len    = len_q;
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign halted      = (state_q == ST_HALT);
    assign load_ovf    = ovf_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer (DEPTH=8, HALT_WORD=8'hFF).
// Latency: n/a.
// Backpressure: core model raises instr_ready on first valid, pulses core_done 3 cycles later.
module tb_prog_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       load_en;
    logic [7:0] load_data;
    logic       clear;
    logic       run;
    logic       step;
    logic       loop_en;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready;
    logic       core_done;
    logic [2:0] pc;
    logic [3:0] prog_len;
    logic       busy;
    logic       halted;
    logic       load_ovf;

    always #5 clock = ~clock;

    prog_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .load_en     (load_en),
        .load_data   (load_data),
        .clear       (clear),
        .run         (run),
        .step        (step),
        .loop_en     (loop_en),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .core_done   (core_done),
        .pc          (pc),
        .prog_len    (prog_len),
        .busy        (busy),
        .halted      (halted),
        .load_ovf    (load_ovf)
    );

    typedef struct {
        logic       clr, ld;
        logic [7:0] dat;
        logic       run, step, rdy, done;
        logic       vld;
        logic [7:0] out;
        logic [2:0] pc;
        logic [3:0] len;
        logic       busy, hlt, ovf;
    } vec_t;

    vec_t       tbl [16];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] iss_q [$];
    bit         saw10;
    bit         saw_halt;

    function automatic vec_t mk(input int clr, input int ld, input int dat, input int rn,
                                input int st, input int rdy, input int dn, input int vld,
                                input int out, input int p, input int len, input int bsy,
                                input int hlt, input int ovf);
        vec_t v;
        v.clr = 1'(clr); v.ld = 1'(ld); v.dat = 8'(dat); v.run = 1'(rn);
        v.step = 1'(st); v.rdy = 1'(rdy); v.done = 1'(dn); v.vld = 1'(vld);
        v.out = 8'(out); v.pc = 3'(p); v.len = 4'(len); v.busy = 1'(bsy);
        v.hlt = 1'(hlt); v.ovf = 1'(ovf);
        return v;
    endfunction

    function automatic logic [18:0] snap();
        return {instr_valid, instr_out, pc, prog_len, busy, halted, load_ovf};
    endfunction

    function automatic logic [18:0] expv(input vec_t v);
        return {v.vld, v.out, v.pc, v.len, v.busy, v.hlt, v.ovf};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        load_en   = 1'b1;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    // Core model: accept the first valid word, finish it 3 cycles later.
    // Stops after 'want' completions, on HALT, or after 'limit' cycles.
    task automatic core_run(input int want, input int limit);
        int dones = 0;
        int cyc   = 0;
        int wcnt  = -1;
        iss_q.delete();
        while (dones < want && !halted && cyc < limit) begin
            instr_ready = 1'b0;
            core_done   = 1'b0;
            if (instr_valid && instr_out == 8'h10) saw10 = 1'b1;
            if (instr_valid && wcnt < 0) begin
                iss_q.push_back(instr_out);
                instr_ready = 1'b1;
                wcnt = 3;
            end else if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) begin
                    core_done = 1'b1;
                    dones++;
                    wcnt = -1;
                end
            end
            tick();
            cyc++;
        end
        instr_ready = 1'b0;
        core_done   = 1'b0;
        if (halted) saw_halt = 1'b1;
        if (cyc >= limit) begin
            n_chk++;
            $display("FAIL core_run timeout: ran %0d cycles, needed fewer than %0d", cyc, limit);
        end
    endtask

    initial begin
        //           clr ld dat    run st rdy dn | vld out   pc len bsy hlt ovf
        tbl[0]  = mk(0, 1, 'h30,  0, 0, 0, 0,   0, 'h00, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 1, 'h30,  0, 0, 0, 0,   0, 'h00, 0, 2, 0, 0, 0);
        tbl[2]  = mk(0, 1, 'h10,  0, 0, 0, 0,   0, 'h00, 0, 3, 0, 0, 0);
        tbl[3]  = mk(0, 0, 'h00,  1, 0, 0, 0,   1, 'h30, 0, 3, 1, 0, 0);
        tbl[4]  = mk(0, 0, 'h00,  1, 0, 0, 1,   1, 'h30, 0, 3, 1, 0, 0);
        tbl[5]  = mk(0, 0, 'h00,  1, 0, 1, 0,   0, 'h00, 0, 3, 1, 0, 0);
        tbl[6]  = mk(0, 1, 'hAA,  1, 0, 0, 0,   0, 'h00, 0, 3, 1, 0, 0);
        tbl[7]  = mk(0, 0, 'h00,  1, 0, 0, 1,   1, 'h30, 1, 3, 1, 0, 0);
        tbl[8]  = mk(0, 0, 'h00,  1, 0, 1, 0,   0, 'h00, 1, 3, 1, 0, 0);
        tbl[9]  = mk(0, 0, 'h00,  1, 0, 0, 1,   1, 'h10, 2, 3, 1, 0, 0);
        tbl[10] = mk(0, 0, 'h00,  1, 0, 1, 0,   0, 'h00, 2, 3, 1, 0, 0);
        tbl[11] = mk(0, 0, 'h00,  1, 0, 0, 1,   0, 'h00, 0, 3, 0, 1, 0);
        tbl[12] = mk(0, 0, 'h00,  1, 1, 0, 0,   0, 'h00, 0, 3, 0, 1, 0);
        tbl[13] = mk(0, 1, 'h55,  0, 0, 0, 0,   0, 'h00, 0, 3, 0, 1, 0);
        tbl[14] = mk(1, 0, 'h00,  0, 0, 0, 0,   0, 'h00, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 'h00,  0, 1, 0, 0,   0, 'h00, 0, 0, 0, 0, 0);

        resetn = 1'b1; load_en = 1'b0; load_data = 8'h00; clear = 1'b0;
        run = 1'b0; step = 1'b0; loop_en = 1'b0; instr_ready = 1'b0; core_done = 1'b0;
        saw10 = 1'b0; saw_halt = 1'b0;

        #1 resetn = 1'b0;
        #1 chk("reset_state", 64'(snap()), 64'h0);
        #10 resetn = 1'b1;
        tick();

        // Table: load, free-run with a fast core, ignored inputs, clear.
        for (int i = 0; i < 16; i++) begin
            clear = tbl[i].clr; load_en = tbl[i].ld; load_data = tbl[i].dat;
            run = tbl[i].run; step = tbl[i].step;
            instr_ready = tbl[i].rdy; core_done = tbl[i].done;
            tick();
            chk($sformatf("vec%0d", i), 64'(snap()), 64'(expv(tbl[i])));
        end
        clear = 1'b0; load_en = 1'b0; run = 1'b0; step = 1'b0;
        instr_ready = 1'b0; core_done = 1'b0;

        // Three-word program with the slow core model.
        load(8'h30); load(8'h30); load(8'h10);
        run = 1'b1;
        core_run(10, 200);
        run = 1'b0;
        chk("run3_issues", {8'(iss_q.size()), iss_q[0], iss_q[1], iss_q[2]}, {8'd3, 8'h30, 8'h30, 8'h10});
        chk("run3_final", {halted, pc, prog_len}, {1'b1, 3'd0, 4'd3});
        do_clear();

        // Fill the buffer, overflow it, then confirm the last entry survived.
        for (int i = 0; i < 8; i++) load(8'(i + 1));
        chk("full_no_ovf", {prog_len, load_ovf}, {4'd8, 1'b0});
        load(8'hEE);
        chk("ovf_set", {prog_len, load_ovf}, {4'd8, 1'b1});
        run = 1'b1;
        core_run(20, 600);
        run = 1'b0;
        chk("ovf_mem7", {8'(iss_q.size()), iss_q[0], iss_q[7]}, {8'd8, 8'h01, 8'h08});
        do_clear();

        // Halt word in the middle of the program.
        load(8'h30); load(8'hFF); load(8'h10);
        saw10 = 1'b0;
        run = 1'b1;
        core_run(10, 200);
        run = 1'b0;
        chk("halt_issues", {8'(iss_q.size()), iss_q[0]}, {8'd1, 8'h30});
        chk("halt_no_10", 64'(saw10), 64'd0);
        chk("halt_state", {halted, busy, instr_valid}, 3'b100);
        do_clear();

        // Single step through a two-word program.
        load(8'h21); load(8'h42);
        pulse_step();
        chk("step1_issue", {busy, instr_valid, instr_out, pc}, {1'b1, 1'b1, 8'h21, 3'd0});
        core_run(1, 50);
        chk("step1_idle", {busy, halted, pc}, {1'b0, 1'b0, 3'd1});
        pulse_step();
        core_run(1, 50);
        chk("step2_word", 64'(iss_q[0]), 64'h42);
        chk("step2_end", {busy, halted, pc}, {1'b0, 1'b1, 3'd0});
        do_clear();

        // Single step with looping: last entry returns to IDLE at pc 0.
        load(8'h21); load(8'h42);
        loop_en = 1'b1;
        pulse_step(); core_run(1, 50);
        pulse_step(); core_run(1, 50);
        chk("step_loop_end", {busy, halted, pc}, {1'b0, 1'b0, 3'd0});

        // Looping free run for five completions.
        saw_halt = 1'b0;
        run = 1'b1;
        core_run(5, 300);
        chk("loop_seq", {8'(iss_q.size()), iss_q[0], iss_q[1], iss_q[2], iss_q[3], iss_q[4]},
            {8'd5, 8'h21, 8'h42, 8'h21, 8'h42, 8'h21});
        chk("loop_no_halt", 64'(saw_halt), 64'd0);

        // Drop run with w1 in flight: it completes, then IDLE at pc 0.
        run = 1'b0;
        core_run(1, 50);
        chk("run_drop", {busy, halted, pc, iss_q[0]}, {1'b0, 1'b0, 3'd0, 8'h42});
        run = 1'b1;
        tick();
        chk("resume_lat", {instr_valid, instr_out, pc}, {1'b1, 8'h21, 3'd0});

        // Asynchronous reset while waiting on the core.
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("in_wait", {busy, instr_valid}, 2'b10);
        #2 resetn = 1'b0;
        #1 chk("reset_in_wait", 64'(snap()), 64'h0);
        run = 1'b0; loop_en = 1'b0;
        #2 resetn = 1'b1;

        // Clear out of HALT.
        load(8'hFF);
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        chk("halt_first", {halted, busy, instr_valid}, 3'b100);
        do_clear();
        chk("clear_halt", {halted, busy, prog_len, pc}, {1'b0, 1'b0, 4'd0, 3'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
